uart_rx_controller: RTL and testbench

- Sequences UART reception around the raw start-bit condition (rx_in low).
- Synchronises rx_in and qualifies the start bit at mid-bit using a 16x oversample tick.
- Samples data, optional parity and stop bits, then delivers each byte through a one-entry valid/ready holding register.
- Sits between the pad-side rx_in and the receive datapath/CPU interface; the baud generator supplies baud_tick.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_controller.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx_in,
  output logic rx_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the line through the two stages
  always_comb begin
    meta_d = rx_in;
    sync_d = meta_q;
  end

  // Synchroniser flops, forced to the idle level on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: start qualification, data/parity/stop sampling and a
// one-entry valid/ready holding register for the received word.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  logic rx_s;

  uart_state_t          state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pe_q, pe_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 deliver;

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .rx_in (rx_in),
    .rx_s  (rx_s)
  );

  // Frame sequencing, sampling decisions and holding-register handshake
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pe_d          = pe_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    parity_err_d  = 1'b0;
    overrun_err_d = 1'b0;
    deliver       = 1'b0;

    case (state_q)
      IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              pe_d       = 1'b0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_cnt_q == TICK_END) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (tick_cnt_q == TICK_END) begin
            pe_d       = (rx_s != ((^shift_q) ^ PAR_MODE));
            tick_cnt_d = '0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end else if (pe_q) begin
              parity_err_d = 1'b1;
              state_d      = IDLE;
            end else begin
              deliver = 1'b1;
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a stuck-low line cannot retrigger
        if (baud_tick && rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // State, counters, shift register, holding register and error pulse flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pe_q          <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pe_q          <= pe_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench: an 8N1 receiver (A) and an 8E1 receiver (B) on separate lines.
module tb_uart_rx_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, baud_tick, rx_ready, tx, sel;
  logic rx_a, rx_b;
  assign rx_a = sel ? 1'b1 : tx;
  assign rx_b = sel ? tx : 1'b1;

  logic [7:0] rx_data_a, rx_data_b;
  logic rx_valid_a, frame_err_a, parity_err_a, overrun_err_a, busy_a;
  logic rx_valid_b, frame_err_b, parity_err_b, overrun_err_b, busy_b;

  uart_rx_controller #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun_err(overrun_err_a),
    .busy(busy_a));

  uart_rx_controller #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun_err(overrun_err_b),
    .busy(busy_b));

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = 0;
  event start_ev;

  int acc_cnt[2]  = '{0, 0};
  int ferr_cnt[2] = '{0, 0};
  int perr_cnt[2] = '{0, 0};
  int ovr_cnt[2]  = '{0, 0};
  logic [7:0] last_data[2];

  typedef struct {
    logic       s;
    logic [7:0] d;
    logic       hp;
    logic       p;
    logic       stp;
    logic [7:0] exp_d;
    int         exp_acc;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[9];

  // baud_tick every 4 clocks, updated 1 time unit after the rising edge
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      phase     = (phase + 1) % 4;
      baud_tick = (phase == 0);
    end
  end

  // Event monitor sampling on the falling edge
  always @(negedge clock) begin
    if (rx_valid_a && rx_ready) begin
      acc_cnt[0]   <= acc_cnt[0] + 1;
      last_data[0] <= rx_data_a;
    end
    if (rx_valid_b && rx_ready) begin
      acc_cnt[1]   <= acc_cnt[1] + 1;
      last_data[1] <= rx_data_b;
    end
    if (frame_err_a)   ferr_cnt[0] <= ferr_cnt[0] + 1;
    if (frame_err_b)   ferr_cnt[1] <= ferr_cnt[1] + 1;
    if (parity_err_a)  perr_cnt[0] <= perr_cnt[0] + 1;
    if (parity_err_b)  perr_cnt[1] <= perr_cnt[1] + 1;
    if (overrun_err_a) ovr_cnt[0]  <= ovr_cnt[0] + 1;
    if (overrun_err_b) ovr_cnt[1]  <= ovr_cnt[1] + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b, input int n);
    tx = b;
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Align the start edge so the receiver detects it on the 3rd edge after launch
  task automatic sync_start();
    do begin
      @(posedge clock);
      #2;
    end while (phase != 2);
    ->start_ev;
  endtask

  task automatic send_frame(input logic s, input logic [7:0] d, input logic hp,
                            input logic p, input logic stp);
    sel = s;
    sync_start();
    bit_out(1'b0, 64);
    for (int i = 0; i < 8; i++) bit_out(d[i], 64);
    if (hp) bit_out(p, 64);
    bit_out(stp, 64);
    tx = 1'b1;
  endtask

  task automatic idle_gap();
    repeat (128) @(posedge clock);
    #2;
  endtask

  initial begin
    int a0, f0, p0, o0;
    logic busy_now;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 0, 0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1, 0, 0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1, 0, 0};
    vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 0};
    vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h00, 0, 0, 1};
    vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1, 0, 0};
    vecs[6] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1, 0, 0};
    vecs[7] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1, 0, 0};
    vecs[8] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0, 1};

    reset = 1'b1; tx = 1'b1; sel = 1'b0; rx_ready = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("reset_rx_valid_a", {31'b0, rx_valid_a}, 0);
    check("reset_rx_data_a", {24'b0, rx_data_a}, 0);
    check("reset_busy_a", {31'b0, busy_a}, 0);
    check("reset_errs_a", {29'b0, frame_err_a, parity_err_a, overrun_err_a}, 0);
    check("reset_rx_valid_b", {31'b0, rx_valid_b}, 0);
    check("reset_busy_b", {31'b0, busy_b}, 0);

    rx_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      int s;
      s  = int'(vecs[v].s);
      a0 = acc_cnt[s]; f0 = ferr_cnt[s]; p0 = perr_cnt[s]; o0 = ovr_cnt[s];
      send_frame(vecs[v].s, vecs[v].d, vecs[v].hp, vecs[v].p, vecs[v].stp);
      idle_gap();
      check($sformatf("vec%0d_accepted", v), acc_cnt[s] - a0, vecs[v].exp_acc);
      if (vecs[v].exp_acc != 0)
        check($sformatf("vec%0d_data", v), {24'b0, last_data[s]}, {24'b0, vecs[v].exp_d});
      check($sformatf("vec%0d_frame_err", v), ferr_cnt[s] - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_parity_err", v), perr_cnt[s] - p0, vecs[v].exp_perr);
      check($sformatf("vec%0d_overrun", v), ovr_cnt[s] - o0, 0);
      busy_now = s ? busy_b : busy_a;
      check($sformatf("vec%0d_busy_idle", v), {31'b0, busy_now}, 0);
    end

    // Start glitch: low for 3 ticks only
    sel = 1'b0;
    a0 = acc_cnt[0]; f0 = ferr_cnt[0]; p0 = perr_cnt[0];
    sync_start();
    bit_out(1'b0, 12);
    check("glitch_busy_in_start", {31'b0, busy_a}, 1);
    tx = 1'b1;
    idle_gap();
    check("glitch_busy", {31'b0, busy_a}, 0);
    check("glitch_accepted", acc_cnt[0] - a0, 0);
    check("glitch_flags", (ferr_cnt[0] - f0) + (perr_cnt[0] - p0), 0);

    // Stop bit low, then line held low 40 ticks: BREAK
    a0 = acc_cnt[0]; f0 = ferr_cnt[0];
    sync_start();
    bit_out(1'b0, 64);
    for (int i = 0; i < 8; i++) bit_out(((8'h3C >> i) & 8'h01) != 0, 64);
    bit_out(1'b0, 64);
    bit_out(1'b0, 160);
    check("break_busy_held", {31'b0, busy_a}, 1);
    check("break_frame_err", ferr_cnt[0] - f0, 1);
    tx = 1'b1;
    idle_gap();
    check("break_busy_release", {31'b0, busy_a}, 0);
    check("break_frame_err_once", ferr_cnt[0] - f0, 1);
    check("break_no_frame", acc_cnt[0] - a0, 0);

    // Overrun: consumer stalled for 0x11 then 0x22
    rx_ready = 1'b0;
    a0 = acc_cnt[0]; o0 = ovr_cnt[0];
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    idle_gap();
    check("ovr_first_valid", {31'b0, rx_valid_a}, 1);
    check("ovr_first_data", {24'b0, rx_data_a}, 32'h11);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle_gap();
    check("ovr_pulse", ovr_cnt[0] - o0, 1);
    check("ovr_data_kept", {24'b0, rx_data_a}, 32'h11);
    check("ovr_none_accepted", acc_cnt[0] - a0, 0);

    // Ready raised exactly in the cycle 0x33 completes (stop sampled at edge 611)
    fork
      send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
      begin
        @(start_ev);
        repeat (610) @(posedge clock);
        #2 rx_ready = 1'b1;
        @(posedge clock);
        #2 rx_ready = 1'b0;
      end
    join
    idle_gap();
    check("simul_accepted", acc_cnt[0] - a0, 1);
    check("simul_accepted_data", {24'b0, last_data[0]}, 32'h11);
    check("simul_rx_data", {24'b0, rx_data_a}, 32'h33);
    check("simul_rx_valid", {31'b0, rx_valid_a}, 1);
    check("simul_no_overrun", ovr_cnt[0] - o0, 1);

    rx_ready = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    check("drain_33", {24'b0, last_data[0]}, 32'h33);

    // Reset during data bit 4 of 0xFF
    a0 = acc_cnt[0];
    fork
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        @(start_ev);
        repeat (340) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("midreset_rx_data", {24'b0, rx_data_a}, 0);
        check("midreset_rx_valid", {31'b0, rx_valid_a}, 0);
        check("midreset_busy", {31'b0, busy_a}, 0);
        check("midreset_errs", {29'b0, frame_err_a, parity_err_a, overrun_err_a}, 0);
      end
    join
    idle_gap();
    check("midreset_no_frame", acc_cnt[0] - a0, 0);
    check("midreset_busy_after", {31'b0, busy_a}, 0);

    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    idle_gap();
    check("post_reset_accepted", acc_cnt[0] - a0, 1);
    check("post_reset_data", {24'b0, last_data[0]}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
